// File: rtl/trace_pkg.sv
// Shared definitions for the commit trace packer and its checker bench:
// record type codes, serializer states and header field positions.
package trace_pkg;

    typedef enum logic [2:0] {
        REC_NOP  = 3'd0,
        REC_REG  = 3'd1,
        REC_LD   = 3'd2,
        REC_STU  = 3'd3,
        REC_ST   = 3'd4,
        REC_HALT = 3'd5
    } recType_t;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        INUM,
        PC,
        PAY
    } state_t;

    localparam int HDR_TYPE_LSB = 13;
    localparam int HDR_REG_LSB  = 10;
    localparam int INUM_WIDTH   = 16;

    // Number of payload words that follow header, inum and pc.
    function automatic logic [1:0] payloadLen(input recType_t recType);
        case (recType)
            REC_REG: payloadLen = 2'd1;
            REC_LD:  payloadLen = 2'd2;
            REC_STU: payloadLen = 2'd3;
            REC_ST:  payloadLen = 2'd2;
            default: payloadLen = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO: each entry holds a type code and the six words of one record.
// A push into a full FIFO succeeds when the head is popped in the same cycle.
module trace_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [2:0]                pushType,
    input  logic [5:0][W-1:0]         pushWords,
    input  logic                      pop,
    output logic [2:0]                headType,
    output logic [5:0][W-1:0]         headWords,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [2:0]        typeMem [DEPTH];
    logic [5:0][W-1:0] wordMem [DEPTH];
    logic [AW-1:0]     rdPtr;
    logic [AW-1:0]     wrPtr;
    logic              doPush;
    logic              doPop;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    assign headType  = typeMem[rdPtr];
    assign headWords = wordMem[rdPtr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (doPush) begin
            typeMem[wrPtr] <= pushType;
            wordMem[wrPtr] <= pushWords;
        end
    end

endmodule

// File: rtl/commit_trace_packer.sv
// Turns each committed instruction into a 3..6 word trace record, queues it,
// and streams the words out over a valid/ready interface.
module commit_trace_packer
    import trace_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         retire_valid,
    input  logic [W-1:0] pc,
    input  logic         reg_write,
    input  logic [2:0]   write_reg,
    input  logic [W-1:0] write_data,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [W-1:0] mem_addr,
    input  logic [W-1:0] mem_data,
    input  logic         halt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         overflow,
    output logic         halted
);

    localparam int CW = $clog2(DEPTH) + 1;

    recType_t              recType;
    recType_t              headType;
    logic [2:0]            headTypeRaw;
    logic [2:0]            regField;
    logic [W-1:0]          hdrWord;
    logic [W-1:0]          inumWord;
    logic [5:0][W-1:0]     recWords;
    logic [5:0][W-1:0]     headWords;
    logic [INUM_WIDTH-1:0] inum;
    logic                  haltSeen;
    logic                  active;
    logic                  accept;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic [CW-1:0]         fifoCount;
    state_t                state;
    state_t                nextState;
    state_t                afterPop;
    logic [1:0]            payIdx;
    logic [1:0]            nextPayIdx;
    logic [1:0]            headLen;
    logic                  lastWord;
    logic                  pop;

    // Classification by priority, then assembly of the record's words.
    always_comb begin
        if (reg_write && mem_write)     recType = REC_STU;
        else if (reg_write && mem_read) recType = REC_LD;
        else if (reg_write)             recType = REC_REG;
        else if (halt)                  recType = REC_HALT;
        else if (mem_write)             recType = REC_ST;
        else                            recType = REC_NOP;

        regField = reg_write ? write_reg : 3'd0;
        hdrWord  = '0;
        hdrWord[HDR_TYPE_LSB +: 3] = recType;
        hdrWord[HDR_REG_LSB +: 3]  = regField;
        inumWord = '0;
        inumWord[INUM_WIDTH-1:0] = inum;

        recWords    = '0;
        recWords[0] = hdrWord;
        recWords[1] = inumWord;
        recWords[2] = pc;
        case (recType)
            REC_REG: recWords[3] = write_data;
            REC_LD: begin
                recWords[3] = write_data;
                recWords[4] = mem_addr;
            end
            REC_STU: begin
                recWords[3] = write_data;
                recWords[4] = mem_addr;
                recWords[5] = mem_data;
            end
            REC_ST: begin
                recWords[3] = mem_addr;
                recWords[4] = mem_data;
            end
            default: ;
        endcase
    end

    assign active = retire_valid && !haltSeen;
    assign accept = active && (!fifoFull || pop);

    trace_fifo #(.DEPTH(DEPTH), .W(W)) recordFifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .pushType  (recType),
        .pushWords (recWords),
        .pop       (pop),
        .headType  (headTypeRaw),
        .headWords (headWords),
        .full      (fifoFull),
        .empty     (fifoEmpty),
        .count     (fifoCount)
    );

    assign headType  = recType_t'(headTypeRaw);
    assign headLen   = payloadLen(headType);
    assign lastWord  = ((state == PC) && (headLen == 2'd0)) ||
                       ((state == PAY) && (payIdx == 2'(headLen - 2'd1)));
    assign out_valid = (state != IDLE);
    assign out_last  = lastWord;
    assign pop       = out_valid && out_ready && lastWord;
    assign afterPop  = ((fifoCount != CW'(1)) || accept) ? HDR : IDLE;

    // Serializer next-state: one step per transferred word.
    always_comb begin
        nextState  = state;
        nextPayIdx = payIdx;
        case (state)
            IDLE: if (!fifoEmpty) nextState = HDR;
            HDR:  if (out_ready) nextState = INUM;
            INUM: if (out_ready) nextState = PC;
            PC: begin
                if (out_ready) begin
                    if (headLen != 2'd0) begin
                        nextState  = PAY;
                        nextPayIdx = 2'd0;
                    end else begin
                        nextState = afterPop;
                    end
                end
            end
            PAY: begin
                if (out_ready) begin
                    if (lastWord) begin
                        nextState  = afterPop;
                        nextPayIdx = 2'd0;
                    end else begin
                        nextPayIdx = payIdx + 2'd1;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        out_data = '0;
        case (state)
            HDR:  out_data = headWords[0];
            INUM: out_data = headWords[1];
            PC:   out_data = headWords[2];
            PAY: begin
                case (payIdx)
                    2'd0:    out_data = headWords[3];
                    2'd1:    out_data = headWords[4];
                    default: out_data = headWords[5];
                endcase
            end
            default: out_data = '0;
        endcase
    end

    // Dropped records still consume an inum; only a taken HALT stops counting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            payIdx   <= 2'd0;
            inum     <= '0;
            overflow <= 1'b0;
            haltSeen <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state  <= nextState;
            payIdx <= nextPayIdx;
            if (active) inum <= inum + 1'b1;
            if (active && !accept) overflow <= 1'b1;
            if (accept && (recType == REC_HALT)) haltSeen <= 1'b1;
            if (pop && (headType == REC_HALT)) halted <= 1'b1;
        end
    end

endmodule
